cdb_commit_reader: RTL
======================

Name: cdb_commit_reader

Overview:
- In-order retirement reader for the CDB result slots.
- Each cycle it watches the reorder-buffer head entry. Once that entry's CDB valid bit is set, it retires the entry: either a register-file write, or a memory store with a req/ack handshake.
- It then returns a one-hot clear to the reorder buffer and advances the head.
- Sits between the CDB slot storage (written on the falling clk edge) and the register file / data-memory write port.

Parameters:
- WORD_SIZE, 32, data/address width
- RB_SIZE, 8, number of reorder-buffer entries (power of two)
- RB_INDEX, 3, log2(RB_SIZE)
- REG_INDEX, 5, register-file address width

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- CDB_data_data  input  WORD_SIZE*RB_SIZE  result word per entry; entry k at bits [k*WORD_SIZE +: WORD_SIZE]
- CDB_data_valid  input  RB_SIZE  result-ready bit per entry
- CDB_data_addr  input  WORD_SIZE*RB_SIZE  store address per entry
- rb_busy  input  RB_SIZE  entry allocated by issue
- rb_is_store  input  RB_SIZE  entry is a store
- rb_dest_bus  input  REG_INDEX*RB_SIZE  destination register per entry
- mem_ack  input  1  memory accepted store
- rf_we  output  1  register-file write strobe (one cycle)
- rf_waddr  output  REG_INDEX  register-file write address
- rf_wdata  output  WORD_SIZE  register-file write data
- mem_req  output  1  store request, held until ack
- mem_addr  output  WORD_SIZE  store address
- mem_wdata  output  WORD_SIZE  store data
- commit_clear  output  RB_SIZE  one-hot, one cycle; frees the entry
- head_ptr  output  RB_INDEX  current head index

Behaviour:
- Reset (synchronous, active-high, dominates everything):
  - all outputs 0; head_ptr=0; FSM=IDLE.
  - Reset during STORE_WAIT drops mem_req in the same edge; no clear is issued.
- "Head ready" means rb_busy[head_ptr] & CDB_data_valid[head_ptr].
- FSM states: IDLE, STORE_WAIT.
- IDLE, head ready, not a store:
  - next edge: rf_we=1, rf_waddr=dest[head], rf_wdata=data[head], commit_clear=1<<head.
  - head_ptr increments by 1, wrapping RB_SIZE-1 -> 0.
  - Stays in IDLE, so back-to-back commits run at 1 per cycle.
- IDLE, head ready, store:
  - next edge: mem_req=1, mem_addr=addr[head], mem_wdata=data[head]; go to STORE_WAIT.
  - rf_we stays 0.
- STORE_WAIT:
  - mem_req, mem_addr and mem_wdata are held stable; CDB inputs are ignored.
  - On the edge where mem_ack=1: mem_req=0, commit_clear=1<<head, head_ptr+1, back to IDLE.
  - The next commit can start in the following cycle at the earliest.
- mem_ack while not in STORE_WAIT: ignored.
- Head not ready (invalid or not busy): stall. Outputs go to 0 except head_ptr; no clear.
- rf_we and commit_clear are single-cycle pulses. They default to 0 every cycle unless set.
- Empty ROB (rb_busy all 0): stays idle indefinitely.
- The CDB updates on negedge, so head readiness is sampled half a cycle after the update. No combinational path exists from CDB inputs to outputs; all outputs are registered.

Optional Feature:
- Macro COMMIT_COUNT_EN.
- Defined:
  - adds output commit_count [31:0], cleared by reset.
  - Increments by 1 on every edge that asserts commit_clear. Covers both register and store commits.
  - Wraps at 2^32.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared parameters file holds WORD_SIZE, RB_SIZE, RB_INDEX and REG_INDEX, plus the state encodings IDLE=0 and STORE_WAIT=1.
- Slice-extraction helpers (data/addr/dest per entry) are functions inside the module.
- One natural sub-module: cdb_head_counter. It is a wrapping RB_INDEX-bit counter with synchronous reset and an advance enable.

Test Plan:
- Reset: assert reset two cycles with CDB_data_valid=8'hFF -> all outputs 0, head_ptr=0, no rf_we.
- ALU commit: entries 0,1 busy, valid, data 32'h11/32'h22, dest 3/4 -> rf_we on two consecutive cycles with (3,0x11) then (4,0x22); commit_clear 8'h01 then 8'h02; head_ptr=2.
- Stall: head entry 2 busy but invalid for 5 cycles, entry 3 valid -> no rf_we and no clear for 5 cycles. When entry 2 becomes valid it commits before entry 3.
- Store handshake: head is a store, addr 0x100, data 0xDEAD, mem_ack held low 3 cycles -> mem_req high and stable 3+ cycles. On ack, commit_clear=1<<head, mem_req=0 next cycle.
- Wrap: head_ptr=7 commits -> head_ptr becomes 0, commit_clear=8'h80.
- COMMIT_COUNT_EN: 5 ALU commits + 1 store -> commit_count=6. Reset in STORE_WAIT -> mem_req=0, commit_count=0.

Source files
------------

// File: rtl/cdb_commit_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdb_commit_reader_pkg
// Description : Shared widths, FSM encodings and helpers for the CDB commit
//               reader.
// Revision    : 1.0 - initial release
// ============================================================================
package cdb_commit_reader_pkg;

    localparam int WORD_SIZE   = 32;
    localparam int RB_SIZE     = 8;
    localparam int RB_INDEX    = 3;
    localparam int REG_INDEX   = 5;
    localparam int COUNT_WIDTH = 32;

    localparam logic [0:0] IDLE       = 1'b0;
    localparam logic [0:0] STORE_WAIT = 1'b1;

    typedef logic [RB_SIZE-1:0]   rb_mask_t;
    typedef logic [RB_INDEX-1:0]  rb_idx_t;
    typedef logic [WORD_SIZE-1:0] word_t;
    typedef logic [REG_INDEX-1:0] reg_idx_t;

    function automatic rb_mask_t rb_onehot(input rb_idx_t idx);
        return rb_mask_t'(1) << idx;
    endfunction

endpackage : cdb_commit_reader_pkg
`default_nettype wire

// File: rtl/cdb_commit_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : cdb_commit_reader_if
// Description : CDB/ROB status inputs plus register-file, memory-store and
//               ROB-clear outputs of the commit reader.
// Revision    : 1.0 - initial release
// ============================================================================
interface cdb_commit_reader_if;
    import cdb_commit_reader_pkg::*;

    logic [WORD_SIZE*RB_SIZE-1:0] CDB_data_data;
    logic [RB_SIZE-1:0]           CDB_data_valid;
    logic [WORD_SIZE*RB_SIZE-1:0] CDB_data_addr;
    logic [RB_SIZE-1:0]           rb_busy;
    logic [RB_SIZE-1:0]           rb_is_store;
    logic [REG_INDEX*RB_SIZE-1:0] rb_dest_bus;
    logic                         mem_ack;

    logic                         rf_we;
    logic [REG_INDEX-1:0]         rf_waddr;
    logic [WORD_SIZE-1:0]         rf_wdata;
    logic                         mem_req;
    logic [WORD_SIZE-1:0]         mem_addr;
    logic [WORD_SIZE-1:0]         mem_wdata;
    logic [RB_SIZE-1:0]           commit_clear;
    logic [RB_INDEX-1:0]          head_ptr;

    // The commit reader itself
    modport master (
        input  CDB_data_data, CDB_data_valid, CDB_data_addr,
        input  rb_busy, rb_is_store, rb_dest_bus, mem_ack,
        output rf_we, rf_waddr, rf_wdata,
        output mem_req, mem_addr, mem_wdata,
        output commit_clear, head_ptr
    );

    // ROB / CDB storage, register file and memory side
    modport slave (
        output CDB_data_data, CDB_data_valid, CDB_data_addr,
        output rb_busy, rb_is_store, rb_dest_bus, mem_ack,
        input  rf_we, rf_waddr, rf_wdata,
        input  mem_req, mem_addr, mem_wdata,
        input  commit_clear, head_ptr
    );

endinterface : cdb_commit_reader_if
`default_nettype wire

// File: rtl/cdb_head_counter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_head_counter
// Description : Wrapping ROB head index with synchronous reset and advance
//               enable.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_head_counter
    import cdb_commit_reader_pkg::*;
#(
    parameter int WIDTH = RB_INDEX
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_advance,
    output      logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Power-of-two ROB depth, so natural overflow is the wrap
    always_comb begin
        count_d = count_q;
        if (i_advance) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule : cdb_head_counter
`default_nettype wire

// File: rtl/cdb_commit_reader.sv
`default_nettype none
// ============================================================================
// Module      : cdb_commit_reader
// Description : In-order ROB retirement: register writes or req/ack memory
//               stores, then a one-hot clear and head advance.
//               Optional macro COMMIT_COUNT_EN adds a 32-bit commit counter.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_commit_reader
    import cdb_commit_reader_pkg::*;
(
    input  wire logic                   clk,
    input  wire logic                   reset,
    cdb_commit_reader_if.master         bus
`ifdef COMMIT_COUNT_EN
    ,
    output      logic [COUNT_WIDTH-1:0] commit_count
`endif
);

    function automatic word_t entry_word(input logic [WORD_SIZE*RB_SIZE-1:0] vec,
                                         input rb_idx_t idx);
        return vec[idx*WORD_SIZE +: WORD_SIZE];
    endfunction

    function automatic reg_idx_t entry_dest(input logic [REG_INDEX*RB_SIZE-1:0] vec,
                                            input rb_idx_t idx);
        return vec[idx*REG_INDEX +: REG_INDEX];
    endfunction

    logic [0:0] state_q, state_d;
    logic       rf_we_q, rf_we_d;
    reg_idx_t   rf_waddr_q, rf_waddr_d;
    word_t      rf_wdata_q, rf_wdata_d;
    logic       mem_req_q, mem_req_d;
    word_t      mem_addr_q, mem_addr_d;
    word_t      mem_wdata_q, mem_wdata_d;
    rb_mask_t   commit_clear_q, commit_clear_d;

    rb_idx_t    head;
    logic       head_ready;
    logic       head_store;
    logic       advance;

    cdb_head_counter #(
        .WIDTH (RB_INDEX)
    ) u_head_counter (
        .clk       (clk),
        .reset     (reset),
        .i_advance (advance),
        .o_count   (head)
    );

    assign head_ready = bus.rb_busy[head] & bus.CDB_data_valid[head];
    assign head_store = bus.rb_is_store[head];

    // State register and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            rf_we_q        <= 1'b0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            commit_clear_q <= '0;
        end else begin
            state_q        <= state_d;
            rf_we_q        <= rf_we_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_wdata_q     <= rf_wdata_d;
            mem_req_q      <= mem_req_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            commit_clear_q <= commit_clear_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (head_ready && head_store) begin
                    state_d = STORE_WAIT;
                end
            end
            STORE_WAIT: begin
                if (bus.mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs fall back to zero each cycle unless a commit or pending store sets them
    always_comb begin
        rf_we_d        = 1'b0;
        rf_waddr_d     = '0;
        rf_wdata_d     = '0;
        mem_req_d      = 1'b0;
        mem_addr_d     = '0;
        mem_wdata_d    = '0;
        commit_clear_d = '0;
        advance        = 1'b0;
        case (state_q)
            IDLE: begin
                if (head_ready) begin
                    if (head_store) begin
                        mem_req_d   = 1'b1;
                        mem_addr_d  = entry_word(bus.CDB_data_addr, head);
                        mem_wdata_d = entry_word(bus.CDB_data_data, head);
                    end else begin
                        rf_we_d        = 1'b1;
                        rf_waddr_d     = entry_dest(bus.rb_dest_bus, head);
                        rf_wdata_d     = entry_word(bus.CDB_data_data, head);
                        commit_clear_d = rb_onehot(head);
                        advance        = 1'b1;
                    end
                end
            end
            STORE_WAIT: begin
                if (bus.mem_ack) begin
                    commit_clear_d = rb_onehot(head);
                    advance        = 1'b1;
                end else begin
                    mem_req_d   = mem_req_q;
                    mem_addr_d  = mem_addr_q;
                    mem_wdata_d = mem_wdata_q;
                end
            end
            default: ;
        endcase
    end

`ifdef COMMIT_COUNT_EN
    logic [COUNT_WIDTH-1:0] commit_count_q, commit_count_d;

    always_comb begin
        commit_count_d = commit_count_q;
        if (advance) begin
            commit_count_d = commit_count_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            commit_count_q <= '0;
        end else begin
            commit_count_q <= commit_count_d;
        end
    end

    assign commit_count = commit_count_q;
`endif

    assign bus.rf_we        = rf_we_q;
    assign bus.rf_waddr     = rf_waddr_q;
    assign bus.rf_wdata     = rf_wdata_q;
    assign bus.mem_req      = mem_req_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.commit_clear = commit_clear_q;
    assign bus.head_ptr     = head;

endmodule : cdb_commit_reader
`default_nettype wire
